// File: rtl/obf_key_loader_if.sv
// rtl/obf_key_loader_if.sv - serial key load handshake and committed key bus
interface obf_key_loader_if #(
  parameter int KEY_WIDTH = 12
);
  logic                 key_load_start;
  logic                 key_sin;
  logic                 key_sin_valid;
  logic [KEY_WIDTH-1:0] key_out;
  logic                 key_valid;
  logic                 key_busy;
  logic                 key_err;

  // Tester / key-ROM side: drives the serial stream, observes the key bus.
  modport master (
    output key_load_start,
    output key_sin,
    output key_sin_valid,
    input  key_out,
    input  key_valid,
    input  key_busy,
    input  key_err
  );

  // Loader side: consumes the serial stream, owns the key bus.
  modport slave (
    input  key_load_start,
    input  key_sin,
    input  key_sin_valid,
    output key_out,
    output key_valid,
    output key_busy,
    output key_err
  );
endinterface

// File: rtl/obf_key_loader.sv
// rtl/obf_key_loader.sv - serial unlock key loader with even-parity check for the obfuscated c432
module obf_key_loader #(
  parameter int                   KEY_WIDTH   = 12,
  parameter logic [KEY_WIDTH-1:0] DEFAULT_KEY = '0,
  parameter int                   TIMEOUT     = 64,
  parameter bit                   LOCK_ONCE   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  obf_key_loader_if.slave   bus
);

  localparam int CNT_W = $clog2(KEY_WIDTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_PARITY = 3'd2,
    S_COMMIT = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  state_t               state_q;
  logic [KEY_WIDTH-1:0] shift_q;
  logic [KEY_WIDTH-1:0] shift_d;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [CNT_W-1:0]     bit_cnt_d;
  logic [TMO_W-1:0]     tmo_cnt_q;
  logic [TMO_W-1:0]     tmo_cnt_d;
  logic                 parity_q;
  logic [KEY_WIDTH-1:0] key_out_q;
  logic                 key_valid_q;
  logic                 key_busy_q;
  logic                 key_err_q;

  logic                 restart;
  logic                 last_bit;
  logic                 tmo_hit;
  logic                 parity_ok;

  // Next values of the shift register and the two saturating counters.
  always_comb begin
    shift_d = shift_q;
    for (int i = 0; i < KEY_WIDTH; i++) begin
      if (bit_cnt_q == CNT_W'(i)) begin
        shift_d[i] = bus.key_sin;
      end
    end
    bit_cnt_d = (bit_cnt_q == CNT_W'(KEY_WIDTH)) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
    tmo_cnt_d = (tmo_cnt_q == TMO_W'(TIMEOUT))   ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
  end

  // A start pulse is honoured everywhere except LOCKED; mid-load it discards
  // the partial key. Even parity: data bits XOR parity bit must be zero.
  assign restart   = bus.key_load_start && (state_q != S_LOCKED);
  assign last_bit  = (bit_cnt_q == CNT_W'(KEY_WIDTH - 1));
  assign tmo_hit   = (tmo_cnt_d == TMO_W'(TIMEOUT));
  assign parity_ok = ~(^shift_q ^ parity_q);

  // Load sequencer; key_out is a separate register touched only by a passing commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      parity_q    <= 1'b0;
      key_out_q   <= DEFAULT_KEY;
      key_valid_q <= 1'b0;
      key_busy_q  <= 1'b0;
      key_err_q   <= 1'b0;
    end else if (restart) begin
      state_q    <= S_SHIFT;
      bit_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      key_err_q  <= 1'b0;
      key_busy_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          key_busy_q <= 1'b0;
        end

        S_SHIFT, S_PARITY: begin
          if (bus.key_sin_valid) begin
            tmo_cnt_q <= '0;
            if (state_q == S_SHIFT) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_d;
              if (last_bit) begin
                state_q <= S_PARITY;
              end
            end else begin
              parity_q <= bus.key_sin;
              state_q  <= S_COMMIT;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_hit) begin
              state_q    <= S_IDLE;
              key_busy_q <= 1'b0;
              key_err_q  <= 1'b1;
            end
          end
        end

        S_COMMIT: begin
          key_busy_q <= 1'b0;
          if (parity_ok) begin
            key_out_q   <= shift_q;
            key_valid_q <= 1'b1;
            state_q     <= LOCK_ONCE ? S_LOCKED : S_IDLE;
          end else begin
            key_err_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end

        S_LOCKED: begin
          key_busy_q <= 1'b0;
        end

        default: begin
          state_q    <= S_IDLE;
          key_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.key_out   = key_out_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_busy  = key_busy_q;
  assign bus.key_err   = key_err_q;

endmodule
